// File: rtl/sdp_ram_be.sv
// sdp_ram_be: simple-dual-port synchronous RAM with byte-lane write enables,
// 1- or 2-cycle read latency, a read-valid strobe and a post-reset clear sweep
// that zeroes every word before user traffic is accepted.
//
// Optional feature macro: RAM_PARITY_EN (per-lane even parity with error
// injection on write and error reporting on read). Undefined by default.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   init_done    high once the clear sweep has finished
//   wr_en        write request (ignored during the clear sweep)
//   wr_addr      write address
//   wr_data      write data
//   wr_be        byte-lane enables, bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
//   wr_perr_inj  invert stored parity of written lanes (parity builds only)
//   rd_en        read request (ignored during the clear sweep)
//   rd_addr      read address
//   rd_data      read data, holds between reads
//   rd_valid     one-cycle strobe per completed read
//   rd_perr      parity error of the completed read, qualified by rd_valid
module sdp_ram_be #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 4,
   parameter int unsigned BYTE_WIDTH   = 8,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned RDW_MODE     = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   output logic                             init_done,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
   input  logic                             wr_perr_inj,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid,
   output logic                             rd_perr
);

   localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam bit WriteFirst     = (RDW_MODE == 1);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  run;
   logic                  rd_go;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_err;

   // ---------------------------------------------------------------------
   // Clear-sweep FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StInit;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StInit: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (&cnt_q) state_d = StRun;
         end
         StRun:   state_d = StRun;
         default: state_d = StInit;
      endcase
   end

   assign run       = (state_q == StRun);
   assign init_done = run;
   assign rd_go     = run & rd_en;

   // ---------------------------------------------------------------------
   // Storage: one array per byte lane so each lane has a plain write port.
   // ---------------------------------------------------------------------
`ifdef RAM_PARITY_EN
   logic [NB-1:0] lane_err;
   assign rd_err = |lane_err;
`else
   logic unused_perr_inj;
   assign unused_perr_inj = wr_perr_inj;
   assign rd_err          = 1'b0;
`endif

   for (genvar i = 0; i < NB; i++) begin : g_lane
      logic [BYTE_WIDTH-1:0] mem_q [DEPTH];
      logic [BYTE_WIDTH-1:0] wr_lane;
      logic                  lane_we;
      logic                  collide;

      assign wr_lane = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      assign lane_we = wr_en & wr_be[i];
      // Only write-first mode forwards the incoming lane on a same-address hit;
      // read-first naturally returns the old word because the array updates
      // at the same edge the read register captures.
      assign collide = WriteFirst & lane_we & (wr_addr == rd_addr);

      always_ff @(posedge clk) begin
         if (!run) begin
            mem_q[cnt_q] <= '0;
         end else if (lane_we) begin
            mem_q[wr_addr] <= wr_lane;
         end
      end

      assign rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = collide ? wr_lane : mem_q[rd_addr];

`ifdef RAM_PARITY_EN
      logic par_q [DEPTH];
      logic wr_par;
      logic rd_par;

      assign wr_par = (^wr_lane) ^ wr_perr_inj;

      always_ff @(posedge clk) begin
         if (!run) begin
            par_q[cnt_q] <= 1'b0;
         end else if (lane_we) begin
            par_q[wr_addr] <= wr_par;
         end
      end

      assign rd_par      = collide ? wr_par : par_q[rd_addr];
      assign lane_err[i] = (^rd_word[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ rd_par;
`endif
   end

   // ---------------------------------------------------------------------
   // Read pipeline: stage 1 always, stage 2 for READ_LATENCY == 2.
   // Data registers load only on a completed read so rd_data holds otherwise.
   // ---------------------------------------------------------------------
   logic                  v1_q;
   logic                  p1_q;
   logic [DATA_WIDTH-1:0] d1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         p1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= rd_go;
         p1_q <= rd_go & rd_err;
         if (rd_go) d1_q <= rd_word;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2_q;
      logic                  p2_q;
      logic [DATA_WIDTH-1:0] d2_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v2_q <= 1'b0;
            p2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v1_q;
            p2_q <= p1_q;
            if (v1_q) d2_q <= d1_q;
         end
      end

      assign rd_valid = v2_q;
      assign rd_perr  = p2_q;
      assign rd_data  = d2_q;
   end else begin : g_lat1
      assign rd_valid = v1_q;
      assign rd_perr  = p1_q;
      assign rd_data  = d1_q;
   end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Directed bench for sdp_ram_be. Three instances share one stimulus stream:
// read-first/latency 1, write-first/latency 1 and read-first/latency 2.
module tb_sdp_ram_be;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, wr_perr_inj, rd_en;
   logic [3:0]  wr_addr, rd_addr, wr_be;
   logic [31:0] wr_data;

   logic        init_done_rf, rd_valid_rf, rd_perr_rf;
   logic [31:0] rd_data_rf;
   logic        init_done_wf, rd_valid_wf, rd_perr_wf;
   logic [31:0] rd_data_wf;
   logic        init_done_l2, rd_valid_l2, rd_perr_l2;
   logic [31:0] rd_data_l2;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef RAM_PARITY_EN
   localparam logic PerrExp = 1'b1;
`else
   localparam logic PerrExp = 1'b0;
`endif

   always #5 clk = ~clk;

   sdp_ram_be #(.READ_LATENCY(1), .RDW_MODE(0)) dut_rf (
      .clk(clk), .rst_n(rst_n), .init_done(init_done_rf),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .wr_perr_inj(wr_perr_inj), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_rf), .rd_valid(rd_valid_rf), .rd_perr(rd_perr_rf)
   );

   sdp_ram_be #(.READ_LATENCY(1), .RDW_MODE(1)) dut_wf (
      .clk(clk), .rst_n(rst_n), .init_done(init_done_wf),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .wr_perr_inj(wr_perr_inj), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_wf), .rd_valid(rd_valid_wf), .rd_perr(rd_perr_wf)
   );

   sdp_ram_be #(.READ_LATENCY(2), .RDW_MODE(0)) dut_l2 (
      .clk(clk), .rst_n(rst_n), .init_done(init_done_l2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .wr_perr_inj(wr_perr_inj), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_l2), .rd_valid(rd_valid_l2), .rd_perr(rd_perr_l2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en       = 1'b0;
      wr_perr_inj = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      wr_be       = '0;
      rd_en       = 1'b0;
      rd_addr     = '0;
   endtask

   task automatic test_reset();
      int n;
      idle();
      rst_n = 1'b0;
      repeat (2) tick();
      n_checks++;
      if ({init_done_rf, rd_valid_rf, rd_perr_rf, rd_data_rf} !== 35'd0)
         $display("FAIL reset_state: got done=%b valid=%b perr=%b data=%h want all 0",
                  init_done_rf, rd_valid_rf, rd_perr_rf, rd_data_rf);
      else n_pass++;
      rst_n = 1'b1;
      n = 0;
      while (!init_done_rf && n < 40) begin
         tick();
         n++;
      end
      n_checks++;
      if (n !== 16) $display("FAIL init_sweep_len: got %0d edges want 16", n);
      else n_pass++;
      n_checks++;
      if (init_done_l2 !== 1'b1) $display("FAIL init_done_l2: got %b want 1", init_done_l2);
      else n_pass++;
   endtask

   task automatic test_clear_read();
      int bad = 0;
      for (int a = 0; a < 16; a++) begin
         rd_en   = 1'b1;
         rd_addr = 4'(a);
         tick();
         if (rd_valid_rf !== 1'b1 || rd_data_rf !== 32'h0) begin
            $display("FAIL clear_read addr %0d: got valid=%b data=%h want 1 00000000",
                     a, rd_valid_rf, rd_data_rf);
            bad++;
         end
      end
      n_checks++;
      if (bad == 0) n_pass++;
      idle();
      tick();
      n_checks++;
      if (rd_valid_rf !== 1'b0) $display("FAIL valid_drop: got %b want 0", rd_valid_rf);
      else n_pass++;
   endtask

   task automatic test_byte_write();
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hAABBCCDD; wr_be = 4'b1111;
      tick();
      wr_data = 32'h11223344; wr_be = 4'b0101;
      tick();
      idle();
      rd_en = 1'b1; rd_addr = 4'd3;
      tick();
      n_checks++;
      if (rd_valid_rf !== 1'b1 || rd_data_rf !== 32'hAA22CC44)
         $display("FAIL byte_merge: got valid=%b data=%h want 1 aa22cc44", rd_valid_rf, rd_data_rf);
      else n_pass++;
      // all-zero enables must not modify the word
      rd_addr = 4'd2;
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0; wr_be = 4'b0000;
      tick();
      n_checks++;
      if (rd_data_rf !== 32'h0) $display("FAIL other_addr: got %h want 00000000", rd_data_rf);
      else n_pass++;
      wr_en = 1'b0; rd_addr = 4'd3;
      tick();
      n_checks++;
      if (rd_data_rf !== 32'hAA22CC44)
         $display("FAIL be_zero_noop: got %h want aa22cc44", rd_data_rf);
      else n_pass++;
      idle();
      tick();
      n_checks++;
      if (rd_valid_rf !== 1'b0 || rd_data_rf !== 32'hAA22CC44)
         $display("FAIL rd_hold: got valid=%b data=%h want 0 aa22cc44", rd_valid_rf, rd_data_rf);
      else n_pass++;
   endtask

   task automatic test_collision();
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
      rd_en = 1'b1; rd_addr = 4'd5;
      tick();
      n_checks++;
      if (rd_data_rf !== 32'h00000000)
         $display("FAIL rdw_read_first: got %h want 00000000", rd_data_rf);
      else n_pass++;
      n_checks++;
      if (rd_valid_wf !== 1'b1 || rd_data_wf !== 32'h0000FFFF)
         $display("FAIL rdw_write_first: got valid=%b data=%h want 1 0000ffff",
                  rd_valid_wf, rd_data_wf);
      else n_pass++;
      // non-colliding write elsewhere while re-reading addr 5
      wr_addr = 4'd6; wr_be = 4'b1111;
      tick();
      n_checks++;
      if (rd_data_rf !== 32'h0000FFFF || rd_data_wf !== 32'h0000FFFF)
         $display("FAIL rdw_no_interact: got rf=%h wf=%h want 0000ffff", rd_data_rf, rd_data_wf);
      else n_pass++;
      n_checks++;
      if (rd_valid_l2 !== 1'b1 || rd_data_l2 !== 32'h00000000)
         $display("FAIL l2_read_first: got valid=%b data=%h want 1 00000000",
                  rd_valid_l2, rd_data_l2);
      else n_pass++;
      idle();
      tick();
      n_checks++;
      if (rd_data_l2 !== 32'h0000FFFF)
         $display("FAIL l2_second: got %h want 0000ffff", rd_data_l2);
      else n_pass++;
   endtask

   task automatic test_latency2();
      logic [31:0] vals [4];
      int bad = 0;
      vals[0] = 32'h11111111; vals[1] = 32'h22222222;
      vals[2] = 32'h33333333; vals[3] = 32'h44444444;
      for (int k = 0; k < 4; k++) begin
         wr_en = 1'b1; wr_addr = 4'(k); wr_data = vals[k]; wr_be = 4'b1111;
         tick();
      end
      idle();
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            rd_en = 1'b1; rd_addr = 4'(k);
         end else begin
            rd_en = 1'b0;
         end
         tick();
         if (rd_valid_l2 !== (k >= 1 && k <= 4)) begin
            $display("FAIL l2_valid edge %0d: got %b want %b", k, rd_valid_l2, (k >= 1 && k <= 4));
            bad++;
         end else if (k >= 1 && k <= 4 && rd_data_l2 !== vals[k-1]) begin
            $display("FAIL l2_data edge %0d: got %h want %h", k, rd_data_l2, vals[k-1]);
            bad++;
         end
         if (k < 4 && (rd_valid_rf !== 1'b1 || rd_data_rf !== vals[k])) begin
            $display("FAIL l1_stream edge %0d: got valid=%b data=%h want 1 %h",
                     k, rd_valid_rf, rd_data_rf, vals[k]);
            bad++;
         end
      end
      n_checks++;
      if (bad == 0) n_pass++;
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      int n;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (rd_data_rf !== 32'h0 || rd_data_l2 !== 32'h0 || init_done_rf !== 1'b0)
         $display("FAIL async_clear: got rf=%h l2=%h done=%b want 0 0 0",
                  rd_data_rf, rd_data_l2, init_done_rf);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c == 4) begin
            wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
            rd_en = 1'b1; rd_addr = 4'd1;
         end else begin
            idle();
         end
         tick();
         if (rd_valid_rf !== 1'b0 || init_done_rf !== 1'b0) begin
            $display("FAIL init_ignore edge %0d: got valid=%b done=%b want 0 0",
                     c, rd_valid_rf, init_done_rf);
            bad++;
         end
      end
      n_checks++;
      if (bad == 0) n_pass++;
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n = 0;
      while (!init_done_rf && n < 40) begin
         tick();
         n++;
      end
      n_checks++;
      if (n !== 16) $display("FAIL reinit_len: got %0d edges want 16", n);
      else n_pass++;
      rd_en = 1'b1; rd_addr = 4'd1;
      tick();
      n_checks++;
      if (rd_valid_rf !== 1'b1 || rd_data_rf !== 32'h0)
         $display("FAIL init_write_ignored: got valid=%b data=%h want 1 00000000",
                  rd_valid_rf, rd_data_rf);
      else n_pass++;
      rd_addr = 4'd0;
      tick();
      n_checks++;
      if (rd_data_rf !== 32'h0) $display("FAIL resweep_clear: got %h want 00000000", rd_data_rf);
      else n_pass++;
      idle();
   endtask

   task automatic test_parity();
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h12345678; wr_be = 4'b1111; wr_perr_inj = 1'b1;
      tick();
      idle();
      rd_en = 1'b1; rd_addr = 4'd7;
      tick();
      n_checks++;
      if (rd_valid_rf !== 1'b1 || rd_data_rf !== 32'h12345678 || rd_perr_rf !== PerrExp)
         $display("FAIL perr_injected: got valid=%b data=%h perr=%b want 1 12345678 %b",
                  rd_valid_rf, rd_data_rf, rd_perr_rf, PerrExp);
      else n_pass++;
      // clean write of the same pattern elsewhere must read back without error
      rd_addr = 4'd2;
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h12345678; wr_be = 4'b0010;
      tick();
      n_checks++;
      if (rd_perr_rf !== 1'b0) $display("FAIL perr_clean: got %b want 0", rd_perr_rf);
      else n_pass++;
      idle();
      rd_en = 1'b1; rd_addr = 4'd9;
      tick();
      n_checks++;
      if (rd_perr_rf !== 1'b0 || rd_data_rf !== 32'h00005600)
         $display("FAIL perr_partial_clean: got perr=%b data=%h want 0 00005600",
                  rd_perr_rf, rd_data_rf);
      else n_pass++;
      idle();
      tick();
      n_checks++;
      if (rd_perr_rf !== 1'b0 || rd_valid_rf !== 1'b0)
         $display("FAIL perr_unqualified: got perr=%b valid=%b want 0 0", rd_perr_rf, rd_valid_rf);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_clear_read();
      test_byte_write();
      test_collision();
      test_latency2();
      test_reset_mid();
      test_parity();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sdp_ram_be.md
# sdp_ram_be

Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port with configurable read latency, a read-valid output, and an internal clear engine that zeroes every word after reset. Next-generation storage primitive for register files, FIFO backing stores and lookup tables. Replaces single-port, always-read RAM instances where concurrent read/write, partial writes or known-zero contents are needed.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
- BYTE_WIDTH, 8, bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- READ_LATENCY, 1, read latency in cycles; legal values 1 or 2
- RDW_MODE, 0, same-address read-during-write: 0 = read-first (old data), 1 = write-first (new data)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once the clear sweep completes; reset 0
- wr_en  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  NB  byte-lane enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
- wr_perr_inj  in  1  parity-error injection (see Configuration)
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data; reset 0
- rd_valid  out  1  rd_data valid strobe; reset 0
- rd_perr  out  1  parity error, qualified by rd_valid; reset 0

## Operation
- FSM states: INIT and RUN. Reset forces INIT with the clear counter at 0.
- INIT: one word is written to zero per cycle at address = counter. After DEPTH cycles (counter at DEPTH-1), the FSM enters RUN and init_done goes to 1.
- INIT: wr_en and rd_en are ignored; no user write occurs; rd_valid stays 0.
- RUN: init_done stays 1 until the next reset.
- Write in RUN: for each lane i with wr_en && wr_be[i], mem[wr_addr] lane i takes the wr_data lane. Other lanes are unchanged. wr_be all-zero is a no-op.
- Read in RUN: rd_en samples rd_addr. Data is returned per Timing.
- Collision (rd_en and wr_en in the same cycle, rd_addr == wr_addr):
  - RDW_MODE 0 returns the pre-write word.
  - RDW_MODE 1 returns the merged word: enabled lanes from wr_data, other lanes old.
  - Different addresses never interact.
- rd_data holds its last value while rd_valid is 0. It changes only when a new read completes.
- Reset asserted mid-operation:
  - rd_valid, rd_data, rd_perr and init_done clear immediately.
  - The read pipeline is flushed.
  - Memory contents are undefined until the new INIT sweep completes.

## Timing
- Clear sweep: init_done rises at the DEPTH-th rising edge after rst_n deasserts (edge 16 for the default).
- READ_LATENCY 1: rd_en at edge t gives rd_data/rd_valid at edge t+1.
- READ_LATENCY 2: adds one output register stage, so data appears at edge t+2. Address, data and valid advance together.
- Full throughput: one read and one write per cycle. Back-to-back reads produce back-to-back rd_valid.
- A write at edge t is visible to a non-colliding read issued at edge t+1.

## Configuration
- RAM_PARITY_EN defined:
  - Each word stores NB extra even-parity bits, one per lane, written with its lane.
  - The INIT sweep writes parity 0.
  - On read, rd_perr = OR of lane parity mismatches, asserted with rd_valid. It is otherwise 0.
  - wr_perr_inj=1 during a write inverts the stored parity bit of every written lane.
- RAM_PARITY_EN undefined:
  - No parity storage.
  - rd_perr is tied 0.
  - wr_perr_inj is ignored.

## Test plan
- Reset, then idle: init_done low for exactly 16 cycles, then high. Read of every address returns 0x00000000, with rd_valid one cycle after each rd_en (READ_LATENCY 1).
- Write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101, then read addr 3: returns 0xAA22CC44.
- Collision on addr 5 (old 0x0, write 0xFFFFFFFF, be=4'b0011): RDW_MODE 0 returns 0x00000000; RDW_MODE 1 returns 0x0000FFFF.
- READ_LATENCY 2, reads of addr 0..3 on consecutive cycles: four consecutive rd_valid pulses starting 2 edges after the first rd_en, data in order.
- Assert rst_n low at cycle 8 of INIT, then release: init_done stays low for a full 16 cycles again. A write/read issued during INIT has no effect and gives no rd_valid.
- RAM_PARITY_EN: write addr 7 with wr_perr_inj=1, then read addr 7: rd_perr=1 with rd_valid. A read of an uninjected address gives rd_perr=0.
